// File: rtl/axi_addr_router.sv
// Address-decoding request router: forwards master requests to one of NUM_SLAVES ports and
// keeps outstanding transactions on a single slave so responses never interleave.
module axi_addr_router #(
    parameter int unsigned NUM_SLAVES = 6,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [NUM_SLAVES-2:0][ADDR_W-1:0] REGION_BASE = {
        32'h2000_0000, 32'h1000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    },
    parameter logic [NUM_SLAVES-2:0][ADDR_W-1:0] REGION_LIMIT = {
        32'h2020_0000, 32'h1000_0400, 32'h0003_0000, 32'h0002_0000, 32'h0000_2000
    }
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [ADDR_W-1:0]             ADDR,
    input  logic                          VALID,
    output logic                          READY,
    output logic [NUM_SLAVES-1:0]         VALID_S,
    input  logic [NUM_SLAVES-1:0]         READY_S,
    input  logic                          RESP_DONE,
    output logic [$clog2(NUM_SLAVES)-1:0] SEL,
    output logic                          BUSY,
    output logic                          DECERR,
    output logic                          UNDERFLOW
);

    localparam int unsigned SelW = $clog2(NUM_SLAVES);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SelW-1:0] DefSlave = SelW'(NUM_SLAVES - 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic            underflow_q, underflow_d;

    logic [SelW-1:0] dec;
    logic            found;
    logic            can_fwd;
    logic            accept;

    // Unsigned offset compare covers base <= addr < limit in one comparison.
    always_comb begin
        dec   = DefSlave;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_SLAVES) - 1; i++) begin
            if (!found && ((ADDR - REGION_BASE[i]) < (REGION_LIMIT[i] - REGION_BASE[i]))) begin
                dec   = SelW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        can_fwd = (state_q == StIdle) || ((dec == sel_q) && (count_q < MaxCnt));
        VALID_S = '0;
        if (VALID && can_fwd) begin
            VALID_S[dec] = 1'b1;
        end
        READY     = VALID && can_fwd && READY_S[dec];
        DECERR    = VALID && (dec == DefSlave);
        accept    = VALID && READY;
        SEL       = sel_q;
        BUSY      = (count_q != '0);
        UNDERFLOW = underflow_q;
    end

    always_comb begin
        count_d     = count_q;
        sel_d       = sel_q;
        underflow_d = underflow_q;
        if (accept) begin
            sel_d = dec;
        end
        if (RESP_DONE && (count_q == '0)) begin
            underflow_d = 1'b1;
        end
        if (accept && !RESP_DONE && (count_q < MaxCnt)) begin
            count_d = count_q + CntW'(1);
        end else if (!accept && RESP_DONE && (count_q != '0)) begin
            count_d = count_q - CntW'(1);
        end
        state_d = (count_d != '0) ? StLocked : StIdle;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= StIdle;
            count_q     <= '0;
            sel_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sel_q       <= sel_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router: sequential vector table plus hand-written sequences
// for outstanding limit, concurrent accept/response, underflow and asynchronous reset.
module tb_axi_addr_router;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] ADDR;
    logic        VALID;
    logic        READY;
    logic [5:0]  VALID_S;
    logic [5:0]  READY_S;
    logic        RESP_DONE;
    logic [2:0]  SEL;
    logic        BUSY;
    logic        DECERR;
    logic        UNDERFLOW;

    int n_total;
    int n_pass;

    axi_addr_router dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ADDR      (ADDR),
        .VALID     (VALID),
        .READY     (READY),
        .VALID_S   (VALID_S),
        .READY_S   (READY_S),
        .RESP_DONE (RESP_DONE),
        .SEL       (SEL),
        .BUSY      (BUSY),
        .DECERR    (DECERR),
        .UNDERFLOW (UNDERFLOW)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [5:0]  rs;
        logic        rd;
        logic [5:0]  exp_vs;
        logic        exp_rdy;
        logic        exp_decerr;
        logic [2:0]  exp_sel;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic v, input logic [5:0] rs, input logic rd,
                       input logic [5:0] evs, input logic erdy, input logic ede,
                       input logic [2:0] esel, input logic ebusy);
        vec_t t;
        t.addr = a; t.valid = v; t.rs = rs; t.rd = rd; t.exp_vs = evs; t.exp_rdy = erdy;
        t.exp_decerr = ede; t.exp_sel = esel; t.exp_busy = ebusy;
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic v, input logic rd);
        ADDR = a; VALID = v; RESP_DONE = rd; READY_S = 6'h3f;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        drive(32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        ARESETn = 1'b0;
        drive(32'h0, 1'b0, 1'b0);

        //   addr          v  rs     rd vs         rdy de sel busy
        add(32'h0000_1000, 1, 6'h3f, 0, 6'b000001, 1, 0, 3'd0, 1);
        add(32'h0002_0004, 1, 6'h3f, 0, 6'b000000, 0, 0, 3'd0, 1);
        add(32'h0002_0004, 1, 6'h3f, 1, 6'b000000, 0, 0, 3'd0, 0);
        add(32'h0002_0004, 1, 6'h3f, 0, 6'b000100, 1, 0, 3'd2, 1);
        add(32'h4000_0000, 1, 6'h3f, 1, 6'b000000, 0, 1, 3'd2, 0);
        add(32'h4000_0000, 1, 6'h3f, 0, 6'b100000, 1, 1, 3'd5, 1);
        add(32'h0001_0000, 0, 6'h3f, 1, 6'b000000, 0, 0, 3'd5, 0);
        add(32'h0000_1fff, 1, 6'h00, 0, 6'b000001, 0, 0, 3'd5, 0);
        add(32'h0000_2000, 1, 6'h3f, 0, 6'b100000, 1, 1, 3'd5, 1);
        add(32'h0001_ffff, 1, 6'h3f, 1, 6'b000000, 0, 0, 3'd5, 0);
        add(32'h0001_ffff, 1, 6'h3f, 0, 6'b000010, 1, 0, 3'd1, 1);
        add(32'h0001_0000, 1, 6'h3f, 1, 6'b000010, 1, 0, 3'd1, 1);
        add(32'h0001_0000, 0, 6'h3f, 1, 6'b000000, 0, 0, 3'd1, 0);
        add(32'h1000_03ff, 1, 6'h3f, 0, 6'b001000, 1, 0, 3'd3, 1);
        add(32'h1000_0400, 0, 6'h3f, 1, 6'b000000, 0, 0, 3'd3, 0);
        add(32'h201f_ffff, 1, 6'h3f, 0, 6'b010000, 1, 0, 3'd4, 1);
        add(32'h2020_0000, 0, 6'h3f, 1, 6'b000000, 0, 0, 3'd4, 0);

        do_reset();
        check("reset busy", 32'(BUSY), 32'd0);
        check("reset sel", 32'(SEL), 32'd0);
        check("reset underflow", 32'(UNDERFLOW), 32'd0);

        foreach (vecs[i]) begin
            ADDR = vecs[i].addr; VALID = vecs[i].valid;
            READY_S = vecs[i].rs; RESP_DONE = vecs[i].rd;
            #1;
            check($sformatf("v%0d valid_s", i), 32'(VALID_S), 32'(vecs[i].exp_vs));
            check($sformatf("v%0d ready", i), 32'(READY), 32'(vecs[i].exp_rdy));
            check($sformatf("v%0d decerr", i), 32'(DECERR), 32'(vecs[i].exp_decerr));
            tick();
            check($sformatf("v%0d sel", i), 32'(SEL), 32'(vecs[i].exp_sel));
            check($sformatf("v%0d busy", i), 32'(BUSY), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d underflow", i), 32'(UNDERFLOW), 32'd0);
        end

        // Outstanding limit: four accepts then a stalled fifth.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(32'h1000_0000, 1'b1, 1'b0);
            #1;
            check($sformatf("lim acc%0d ready", k), 32'(READY), 32'd1);
            tick();
        end
        drive(32'h1000_0000, 1'b1, 1'b0);
        #1;
        check("lim full ready", 32'(READY), 32'd0);
        check("lim full valid_s", 32'(VALID_S), 32'd0);
        RESP_DONE = 1'b1;
        #1;
        check("lim full+rd ready", 32'(READY), 32'd0);
        tick();
        RESP_DONE = 1'b0;
        #1;
        check("lim fifth ready", 32'(READY), 32'd1);
        check("lim fifth valid_s", 32'(VALID_S), 32'(6'b001000));
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(32'h0, 1'b0, 1'b1);
            tick();
            check($sformatf("lim drain%0d busy", k), 32'(BUSY), (k == 3) ? 32'd0 : 32'd1);
        end

        // Concurrent accept and response hold count; then underflow.
        do_reset();
        drive(32'h0000_0100, 1'b1, 1'b0);
        tick();
        tick();
        drive(32'h0000_0100, 1'b1, 1'b1);
        #1;
        check("conc ready", 32'(READY), 32'd1);
        tick();
        drive(32'h0, 1'b0, 1'b1);
        tick();
        check("conc after rd1 busy", 32'(BUSY), 32'd1);
        tick();
        check("conc after rd2 busy", 32'(BUSY), 32'd0);
        tick();
        check("uf flag", 32'(UNDERFLOW), 32'd1);
        check("uf busy", 32'(BUSY), 32'd0);
        drive(32'h0002_0000, 1'b1, 1'b0);
        tick();
        check("uf accept sel", 32'(SEL), 32'd2);
        drive(32'h0, 1'b0, 1'b1);
        tick();
        check("uf no wrap busy", 32'(BUSY), 32'd0);
        check("uf sticky", 32'(UNDERFLOW), 32'd1);

        // Asynchronous reset mid-transaction.
        drive(32'h0000_0000, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(32'h0001_0000, 1'b1, 1'b0);
            tick();
        end
        drive(32'h0002_0000, 1'b1, 1'b0);
        #2;
        ARESETn = 1'b0;
        #1;
        check("arst busy", 32'(BUSY), 32'd0);
        check("arst sel", 32'(SEL), 32'd0);
        check("arst underflow", 32'(UNDERFLOW), 32'd0);
        tick();
        check("arst held busy", 32'(BUSY), 32'd0);
        #1;
        ARESETn = 1'b1;
        #1;
        check("post rst valid_s", 32'(VALID_S), 32'(6'b000100));
        check("post rst ready", 32'(READY), 32'd1);
        tick();
        check("post rst sel", 32'(SEL), 32'd2);
        check("post rst busy", 32'(BUSY), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
